// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the dual-port SRAM arbiter slice.
package sram_arb_pkg;

    localparam int ADDR_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_WMASKS_DEF = 4;
    localparam int MAX_WAIT_DEF   = 16;

    // Arbitration state for macro port 0.
    typedef enum logic [1:0] {
        RR       = 2'd0,
        B_LOCK   = 2'd1,
        OVERRIDE = 2'd2
    } arb_state_t;

    // Owner of an in-flight port-0 read.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

endpackage

// File: rtl/sram_arb_fsm.sv
// Port-0 arbitration: round-robin between A and B, B burst lock, and a
// starvation override that lets A through once after MAX_WAIT waiting cycles.
module sram_arb_fsm
    import sram_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic a_valid,
    input  logic b_valid,
    input  logic b_lock,
    output logic a_ready,
    output logic b_ready
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             last_grant_a, last_grant_a_nxt;
    logic             a_grant, b_grant;
    logic             wait_full;

    assign a_grant   = a_valid && a_ready;
    assign b_grant   = b_valid && b_ready;
    assign wait_full = (wait_cnt == CNT_W'(MAX_WAIT));

    // Ready generation: each ready depends only on state and the other requester's valid.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that leaves one unassigned would infer a latch.
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!reset) begin
            case (state)
                RR: begin
                    a_ready = !b_valid || !last_grant_a;
                    b_ready = !a_valid || last_grant_a;
                end
                B_LOCK:   b_ready = 1'b1;
                OVERRIDE: a_ready = 1'b1;
                default:  ;
            endcase
        end
    end

    // Next-state, wait counter and round-robin flag update.
    always_comb begin
        state_nxt        = state;
        wait_cnt_nxt     = wait_cnt;
        last_grant_a_nxt = last_grant_a;
        if (a_grant) begin
            last_grant_a_nxt = 1'b1;
        end else if (b_grant) begin
            last_grant_a_nxt = 1'b0;
        end
        case (state)
            RR: begin
                wait_cnt_nxt = '0;
                if (b_grant && b_lock) state_nxt = B_LOCK;
            end
            B_LOCK: begin
                if (!b_lock) begin
                    state_nxt    = RR;
                    wait_cnt_nxt = '0;
                end else if (a_valid && wait_full) begin
                    state_nxt    = OVERRIDE;
                    wait_cnt_nxt = '0;
                end else if (a_valid) begin
                    // Saturation is implicit: a full counter with a_valid always leaves B_LOCK.
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            OVERRIDE: begin
                wait_cnt_nxt = '0;
                // Leave after A's single transfer, or if A withdrew so B is not blocked forever.
                if (a_grant || !a_valid) state_nxt = b_lock ? B_LOCK : RR;
            end
            default: state_nxt = RR;
        endcase
    end

    // State registers; A is favoured first out of reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state        <= RR;
            wait_cnt     <= '0;
            last_grant_a <= 1'b0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_cnt_nxt;
            last_grant_a <= last_grant_a_nxt;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares macro port 0 between A and B, passes fetch to port 1, registers all
// macro inputs and routes read data back to the issuing requester.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_WMASKS = NUM_WMASKS_DEF,
    parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [NUM_WMASKS-1:0] a_wmask,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [NUM_WMASKS-1:0] b_wmask,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    input  logic                  b_lock,
    input  logic                  f_valid,
    output logic                  f_ready,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_rvalid,
    output logic [DATA_WIDTH-1:0] f_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);

    logic                  a_grant, b_grant, p0_grant, f_grant;
    logic                  win_we;
    logic [NUM_WMASKS-1:0] win_wmask;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    owner_t                p0_tag_s1, p0_tag_s2;
    logic                  f_pend_s1, f_pend_s2;

    sram_arb_fsm #(.MAX_WAIT(MAX_WAIT)) u_fsm (
        .clk     (clk),
        .reset   (reset),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .b_lock  (b_lock),
        .a_ready (a_ready),
        .b_ready (b_ready)
    );

    assign a_grant  = a_valid && a_ready;
    assign b_grant  = b_valid && b_ready;
    assign p0_grant = a_grant || b_grant;

    // The FSM never grants both, so selecting on a_grant picks the winner.
    assign win_we    = a_grant ? a_we    : b_we;
    assign win_wmask = a_grant ? a_wmask : b_wmask;
    assign win_addr  = a_grant ? a_addr  : b_addr;
    assign win_wdata = a_grant ? a_wdata : b_wdata;

    // Fetch stalls only behind a same-cycle port-0 write to its own address.
    assign f_ready = !reset && !(p0_grant && win_we && (win_addr == f_addr));
    assign f_grant = f_valid && f_ready;

    // Port-0 command registers; address and data hold while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= '0;
            addr0  <= '0;
            din0   <= '0;
        end else if (p0_grant) begin
            csb0   <= 1'b0;
            web0   <= !win_we;
            wmask0 <= win_we ? win_wmask : '0;
            addr0  <= win_addr;
            din0   <= win_wdata;
        end else begin
            csb0   <= 1'b1;
        end
    end

    // Port-1 command registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            csb1  <= 1'b1;
            addr1 <= '0;
        end else begin
            csb1 <= !f_grant;
            if (f_grant) addr1 <= f_addr;
        end
    end

    // Owner tag pipeline: stage 1 during the macro cycle, stage 2 during the response cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            p0_tag_s1 <= OWN_NONE;
            p0_tag_s2 <= OWN_NONE;
            f_pend_s1 <= 1'b0;
            f_pend_s2 <= 1'b0;
        end else begin
            if (a_grant && !a_we) begin
                p0_tag_s1 <= OWN_A;
            end else if (b_grant && !b_we) begin
                p0_tag_s1 <= OWN_B;
            end else begin
                p0_tag_s1 <= OWN_NONE;
            end
            p0_tag_s2 <= p0_tag_s1;
            f_pend_s1 <= f_grant;
            f_pend_s2 <= f_pend_s1;
        end
    end

    // Response capture: each rdata only changes when its owner's read returns.
    always_ff @(posedge clk) begin
        // NOTE: rdata registers are held outputs, so they are reset; the macro array itself never is.
        if (reset) begin
            a_rdata <= '0;
            b_rdata <= '0;
            f_rdata <= '0;
        end else begin
            if (p0_tag_s1 == OWN_A) a_rdata <= dout0;
            if (p0_tag_s1 == OWN_B) b_rdata <= dout0;
            if (f_pend_s1)          f_rdata <= dout1;
        end
    end

    assign a_rvalid = (p0_tag_s2 == OWN_A);
    assign b_rvalid = (p0_tag_s2 == OWN_B);
    assign f_rvalid = f_pend_s2;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural SRAM macro model.
module tb_sram_port_arbiter;

    localparam int AW       = 8;
    localparam int DW       = 32;
    localparam int MW       = 4;
    localparam int MAX_WAIT = 16;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_valid, a_ready, a_we, a_rvalid;
    logic [MW-1:0] a_wmask;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_valid, b_ready, b_we, b_rvalid, b_lock;
    logic [MW-1:0] b_wmask;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          f_valid, f_ready, f_rvalid;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_rdata;
    logic          csb0, web0, csb1;
    logic [MW-1:0] wmask0;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, dout0, dout1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference state: memory contents and expected responses in issue order.
    logic [DW-1:0] ref_mem [256];
    exp_t          qa[$], qb[$], qf[$];
    // Arbitration rules kept as plain flags.
    bit            favour_a, locked, ovr;
    int            starve;

    // Macro model array.
    logic [DW-1:0] mac_mem [256];

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_wmask(a_wmask),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_wmask(b_wmask),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .b_lock(b_lock),
        .f_valid(f_valid), .f_ready(f_ready), .f_addr(f_addr),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(dout0), .csb1(csb1), .addr1(addr1), .dout1(dout1)
    );

    // Macro: accesses the registered command mid-cycle, data ready before the next edge.
    always @(negedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int i = 0; i < MW; i++)
                    if (wmask0[i]) mac_mem[addr0][8*i +: 8] = din0[8*i +: 8];
            end else begin
                dout0 <= mac_mem[addr0];
            end
        end
        if (!csb1) dout1 <= mac_mem[addr1];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic missing(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: response missing or unexpected (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops an expectation whenever the DUT presents a response.
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0 && qa[0].due < cyc) begin void'(qa.pop_front()); missing("a_rsp_late"); end
        if (qb.size() > 0 && qb[0].due < cyc) begin void'(qb.pop_front()); missing("b_rsp_late"); end
        if (qf.size() > 0 && qf[0].due < cyc) begin void'(qf.pop_front()); missing("f_rsp_late"); end
        if (a_rvalid === 1'b1) begin
            if (qa.size() == 0) missing("a_rsp_extra");
            else begin e = qa.pop_front(); check("a_rdata", a_rdata, e.data); check("a_rsp_cycle", cyc, e.due); end
        end
        if (b_rvalid === 1'b1) begin
            if (qb.size() == 0) missing("b_rsp_extra");
            else begin e = qb.pop_front(); check("b_rdata", b_rdata, e.data); check("b_rsp_cycle", cyc, e.due); end
        end
        if (f_rvalid === 1'b1) begin
            if (qf.size() == 0) missing("f_rsp_extra");
            else begin e = qf.pop_front(); check("f_rdata", f_rdata, e.data); check("f_rsp_cycle", cyc, e.due); end
        end
    end

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r = old;
        for (int i = 0; i < MW; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // One cycle: compare readiness with the rules, record handshakes, advance to the next cycle.
    task automatic tick();
        bit ea, eb, ef, ga, gb;
        #1;
        if (reset) begin
            ea = 0; eb = 0; ef = 0;
        end else if (ovr) begin
            ea = 1; eb = 0;
        end else if (locked) begin
            ea = 0; eb = 1;
        end else begin
            ea = !b_valid || favour_a;
            eb = !a_valid || !favour_a;
        end
        ga = a_valid && ea;
        gb = b_valid && eb;
        if (!reset)
            ef = !((ga && a_we && a_addr == f_addr) || (gb && b_we && b_addr == f_addr));
        check("a_ready", a_ready, ea);
        check("b_ready", b_ready, eb);
        check("f_ready", f_ready, ef);
        if (reset) begin
            while (qa.size() > 0 && qa[$].due > cyc) void'(qa.pop_back());
            while (qb.size() > 0 && qb[$].due > cyc) void'(qb.pop_back());
            while (qf.size() > 0 && qf[$].due > cyc) void'(qf.pop_back());
            favour_a = 1; locked = 0; ovr = 0; starve = 0;
        end else begin
            if (f_valid && ef) qf.push_back('{ref_mem[f_addr], cyc + 2});
            if (ga) begin
                if (a_we) ref_mem[a_addr] = merge(ref_mem[a_addr], a_wdata, a_wmask);
                else qa.push_back('{ref_mem[a_addr], cyc + 2});
            end
            if (gb) begin
                if (b_we) ref_mem[b_addr] = merge(ref_mem[b_addr], b_wdata, b_wmask);
                else qb.push_back('{ref_mem[b_addr], cyc + 2});
            end
            if (ovr) begin
                if (ga || !a_valid) begin ovr = 0; locked = b_lock; starve = 0; end
            end else if (locked) begin
                if (!b_lock) begin locked = 0; starve = 0; end
                else if (a_valid && starve == MAX_WAIT) begin locked = 0; ovr = 1; starve = 0; end
                else if (a_valid) starve++;
            end else if (gb && b_lock) begin
                locked = 1; starve = 0;
            end
            if (ga) favour_a = 0;
            if (gb) favour_a = 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        a_valid = 0; b_valid = 0; f_valid = 0;
    endtask

    task automatic a_req(input logic we, input logic [3:0] m, input logic [7:0] ad, input logic [31:0] d);
        a_valid = 1; a_we = we; a_wmask = m; a_addr = ad; a_wdata = d;
    endtask

    task automatic check_reset_outputs();
        check("rst_csb0", csb0, 1);  check("rst_web0", web0, 1);
        check("rst_wmask0", wmask0, 0); check("rst_addr0", addr0, 0);
        check("rst_din0", din0, 0);  check("rst_csb1", csb1, 1);
        check("rst_addr1", addr1, 0);
        check("rst_rvalid", {a_rvalid, b_rvalid, f_rvalid}, 0);
        check("rst_a_rdata", a_rdata, 0); check("rst_b_rdata", b_rdata, 0);
        check("rst_f_rdata", f_rdata, 0);
    endtask

    function automatic logic [7:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return 8'h20;
        return 8'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin mac_mem[i] = '0; ref_mem[i] = '0; end
        dout0 = '0; dout1 = '0;
        reset = 1; b_lock = 0;
        a_we = 0; a_wmask = 0; a_addr = 0; a_wdata = 0;
        b_we = 0; b_wmask = 0; b_addr = 0; b_wdata = 0; f_addr = 0;
        idle();
        @(posedge clk); #1;
        tick(); tick();
        reset = 0;
        check_reset_outputs();

        // Full write then read-back on the next cycle.
        a_req(1, 4'hF, 8'h10, 32'hDEADBEEF); tick();
        a_req(0, 4'h0, 8'h10, 32'h0);        tick();
        idle(); tick(); tick(); tick();

        // Partial write over a known background.
        a_req(1, 4'hF, 8'h11, 32'hAAAAAAAA); tick();
        a_req(1, 4'h5, 8'h11, 32'h11223344); tick();
        a_req(0, 4'h0, 8'h11, 32'h0);        tick();
        idle(); tick(); tick(); tick();

        // A and B both reading: grants alternate.
        for (int i = 0; i < 4; i++) begin
            a_req(0, 4'h0, 8'h10, 32'h0);
            b_valid = 1; b_we = 0; b_addr = 8'h11;
            tick();
        end
        idle(); tick(); tick(); tick();

        // B lock stream with A waiting, then release.
        b_lock = 1;
        for (int i = 0; i < 45; i++) begin
            a_req(0, 4'h0, 8'(i % 4), 32'h0);
            b_valid = 1; b_we = (i % 3 == 0); b_wmask = 4'hF;
            b_addr = 8'(i % 4); b_wdata = 32'h1000 + i;
            tick();
        end
        b_lock = 0;
        for (int i = 0; i < 4; i++) tick();
        idle(); tick(); tick(); tick();

        // Fetch collision with a same-address write.
        a_req(1, 4'hF, 8'h20, 32'h5A5A1234);
        f_valid = 1; f_addr = 8'h20;
        tick();
        a_valid = 0; tick();
        idle(); tick(); tick(); tick();

        // Reset one cycle after a read handshake drops the response.
        a_req(0, 4'h0, 8'h10, 32'h0); tick();
        idle(); reset = 1; tick(); tick();
        reset = 0;
        check_reset_outputs();
        tick(); tick(); tick();

        // Randomized traffic.
        for (int i = 0; i < 900; i++) begin
            a_valid = ($urandom_range(0, 9) < 7); a_we = 1'($urandom_range(0, 1));
            a_wmask = 4'($urandom); a_addr = pick_addr(); a_wdata = $urandom;
            b_valid = ($urandom_range(0, 9) < 7); b_we = 1'($urandom_range(0, 1));
            b_wmask = 4'($urandom); b_addr = pick_addr(); b_wdata = $urandom;
            if ($urandom_range(0, 19) == 0) b_lock = !b_lock;
            f_valid = 1'($urandom_range(0, 1)); f_addr = pick_addr();
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end

        reset = 0; b_lock = 0; idle();
        for (int i = 0; i < 5; i++) tick();
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        check("f_queue_drained", qf.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
